// File: rtl/dot_arbiter.sv
// dot_arbiter: round-robin sharing of one fixed-latency dot-product pipeline between R requesters,
// with results tagged by requester id and buffered in a credit-protected first-word-fall-through FIFO.
module dot_arbiter #(
    parameter int N     = 4,
    parameter int R     = 4,
    parameter int LAT   = 6,
    parameter int DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [R-1:0]          req_valid,
    input  logic [R*N*32-1:0]     req_data,
    output logic [R-1:0]          req_ready,
    output logic [N*32-1:0]       dot_data,
    output logic                  dot_issue,
    input  logic [31:0]           dot_out,
    output logic                  res_valid,
    output logic [31:0]           res_data,
    output logic [$clog2(R)-1:0]  res_id,
    input  logic                  res_ready,
    output logic                  busy
);
    localparam int IW = $clog2(R);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IW:0]   R_EXT = (IW + 1)'(R);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_id;
    logic [IW-1:0] next_ptr;
    logic [IW-1:0] issue_id;
    logic [IW:0]   cand;
    logic          grant_found;
    logic          grant;
    logic [CW-1:0] credits;
    logic [CW-1:0] fifo_count;
    logic [LAT-1:0] tag_valid;
    logic [IW-1:0] tag_id [LAT];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   mem_data [DEPTH];
    logic [IW-1:0] mem_id [DEPTH];
    logic          push;
    logic          pop;

    // Rotating priority search: first valid requester at or after ptr, wrapping modulo R.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = 0; i < R; i++) begin
            cand = {1'b0, ptr} + (IW + 1)'(i);
            if (cand >= R_EXT) begin
                cand = cand - R_EXT;
            end
            if (!grant_found && req_valid[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IW-1:0];
            end
        end
    end

    // The grant is gated by reset so req_ready drops the instant reset asserts.
    assign grant     = grant_found && (credits != '0) && resetn;
    assign req_ready = grant ? (R'(1) << grant_id) : '0;
    assign next_ptr  = (grant_id == IW'(R - 1)) ? '0 : grant_id + IW'(1);

    assign push      = tag_valid[LAT-1];
    assign pop       = res_valid && res_ready;

    // A credit is taken at grant time and returned when the consumer pops a result.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr       <= '0;
            dot_issue <= 1'b0;
            dot_data  <= '0;
            issue_id  <= '0;
            credits   <= FULL;
        end else begin
            dot_issue <= grant;
            if (grant) begin
                dot_data <= req_data[int'(grant_id) * N * 32 +: N * 32];
                issue_id <= grant_id;
                ptr      <= next_ptr;
            end
            credits <= credits - CW'(grant) + CW'(pop);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tag_valid <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid[0] <= dot_issue;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < LAT; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= dot_out;
            mem_id[wr_ptr]   <= tag_id[LAT-1];
        end
    end

    assign res_valid = (fifo_count != '0);
    assign res_data  = res_valid ? mem_data[rd_ptr] : '0;
    assign res_id    = res_valid ? mem_id[rd_ptr] : '0;
    assign busy      = (|tag_valid) || res_valid || dot_issue;

    overflow_check: assert property (@(posedge clock) disable iff (!resetn)
        !(push && !pop && fifo_count == FULL));

endmodule

// File: tb/tb_dot_arbiter.sv
// tb_dot_arbiter: randomized and directed stimulus against a transaction-level model of the arbiter;
// the bench also stands in for the dot pipeline, returning a fold of each issued vector LAT cycles later.
module tb_dot_arbiter;
    localparam int N     = 4;
    localparam int R     = 4;
    localparam int LAT   = 6;
    localparam int DEPTH = 8;
    localparam int IW    = $clog2(R);

    logic                 clock = 1'b0;
    logic                 resetn;
    logic [R-1:0]         req_valid;
    logic [R*N*32-1:0]    req_data;
    logic [R-1:0]         req_ready;
    logic [N*32-1:0]      dot_data;
    logic                 dot_issue;
    logic [31:0]          dot_out;
    logic                 res_valid;
    logic [31:0]          res_data;
    logic [IW-1:0]        res_id;
    logic                 res_ready;
    logic                 busy;

    dot_arbiter #(.N(N), .R(R), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .dot_data  (dot_data),
        .dot_issue (dot_issue),
        .dot_out   (dot_out),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int grant_count = 0;

    typedef struct {
        int          id;
        logic [31:0] val;
        int          gcyc;
        int          vis;
    } exp_t;

    exp_t            exp_q[$];
    int              m_ptr = 0;
    int              m_credits = DEPTH;
    bit              m_issue = 1'b0;
    logic [N*32-1:0] m_vec = '0;

    logic [31:0] sched_val [64];
    bit          sched_v [64];

    function automatic logic [31:0] lane_fold(input logic [N*32-1:0] v);
        logic [31:0] s;
        s = 32'h5a5a_0000;
        for (int i = 0; i < N; i++) begin
            s = {s[30:0], s[31]} ^ v[i*32 +: 32];
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [N*32-1:0] got, input logic [N*32-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pipeline stand-in: a result for each issue appears on dot_out exactly LAT cycles later.
    always @(negedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
            dot_out = '0;
        end else begin
            dot_out = sched_v[cyc % 64] ? sched_val[cyc % 64] : $urandom;
            sched_v[cyc % 64] = 1'b0;
            if (dot_issue) begin
                sched_val[(cyc + LAT) % 64] = lane_fold(dot_data);
                sched_v[(cyc + LAT) % 64]   = 1'b1;
            end
        end
    end

    task automatic model_step();
        int              g;
        bit              found;
        bit              granted;
        bit              head_ok;
        bit              exp_busy;
        logic [R-1:0]    exp_ready;
        logic [N*32-1:0] vec;
        exp_t            e;

        found = 1'b0;
        g = 0;
        for (int i = 0; i < R; i++) begin
            if (!found && req_valid[(m_ptr + i) % R]) begin
                found = 1'b1;
                g = (m_ptr + i) % R;
            end
        end
        granted   = found && (m_credits > 0);
        exp_ready = granted ? (R'(1) << g) : '0;
        if (req_ready != '0) grant_count++;

        exp_busy = 1'b0;
        foreach (exp_q[k]) if (exp_q[k].gcyc < cyc) exp_busy = 1'b1;
        head_ok = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);

        checkOutput("req_ready", req_ready, exp_ready);
        checkOutput("dot_issue", dot_issue, m_issue);
        if (m_issue) checkOutput("dot_data", dot_data, m_vec);
        checkOutput("busy", busy, exp_busy);
        checkOutput("res_valid", res_valid, head_ok);
        if (head_ok) begin
            checkOutput("res_id", res_id, exp_q[0].id);
            checkOutput("res_data", res_data, exp_q[0].val);
        end

        if (head_ok && res_ready) begin
            void'(exp_q.pop_front());
            m_credits++;
        end
        m_issue = granted;
        if (granted) begin
            vec    = req_data[g*N*32 +: N*32];
            m_vec  = vec;
            e.id   = g;
            e.val  = lane_fold(vec);
            e.gcyc = cyc;
            e.vis  = cyc + LAT + 2;
            exp_q.push_back(e);
            m_credits--;
            m_ptr = (g + 1) % R;
        end
    endtask

    task automatic applyStimulus(input logic [R-1:0] v, input logic rr);
        req_valid = v;
        res_ready = rr;
        for (int k = 0; k < R * N; k++) req_data[k*32 +: 32] = $urandom;
        @(negedge clock);
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, '0);
        checkOutput({tag, "_dot_issue"}, dot_issue, '0);
        checkOutput({tag, "_dot_data"}, dot_data, '0);
        checkOutput({tag, "_res_valid"}, res_valid, '0);
        checkOutput({tag, "_res_data"}, res_data, '0);
        checkOutput({tag, "_res_id"}, res_id, '0);
        checkOutput({tag, "_busy"}, busy, '0);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_credits = DEPTH;
        m_ptr     = 0;
        m_issue   = 1'b0;
    endtask

    task automatic drain();
        repeat (DEPTH + LAT + 8) applyStimulus('0, 1'b1);
    endtask

    task automatic saturate_and_count(input string tag);
        grant_count = 0;
        repeat (20) applyStimulus('1, 1'b0);
        checkOutput(tag, grant_count, DEPTH);
    endtask

    initial begin
        resetn    = 1'b0;
        req_valid = '1;
        req_data  = '0;
        res_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        req_valid = '0;
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        // Lone requester 2: grant now, issue next cycle, tagged result LAT+2 cycles after grant.
        applyStimulus(4'b0100, 1'b1);
        repeat (LAT + 4) applyStimulus('0, 1'b1);

        repeat (20) applyStimulus('1, 1'b1);
        drain();

        saturate_and_count("sat_issues");
        drain();

        // Leave ptr at 2, then only requesters 1 and 3 compete.
        applyStimulus(4'b0010, 1'b1);
        repeat (3) applyStimulus(4'b1010, 1'b1);
        drain();

        repeat (300) applyStimulus(R'($urandom), ($urandom_range(0, 3) != 0));
        drain();

        // Asynchronous reset with results still in flight.
        repeat (5) applyStimulus('1, 1'b0);
        #2 resetn = 1'b0;
        #1;
        check_all_zero("midreset");
        model_clear();
        req_valid = '0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        repeat (LAT + 6) applyStimulus('0, 1'b1);
        saturate_and_count("post_reset_issues");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
